uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one physical UART TX pin between two byte-stream requesters: port 0 is the telemetry/sysmon packet source, port 1 is the SoC debug/console source.
- Each requester holds the line for a whole packet, delimited by a `last` flag. Packets from the two ports are never interleaved on the wire.
- Contains the single 8N1 serializer driving the pin.
- Grants the line round-robin between packets, and releases a stalled owner after a timeout.

Parameters:
- CLK_FREQ, 20000000: clk frequency in Hz.
- BAUD_RATE, 125000: line rate. BIT_PERIOD = CLK_FREQ/BAUD_RATE, integer division; elaboration error if BIT_PERIOD < 2.
- LOCK_TIMEOUT, 1000000: clk cycles an owner may idle mid-packet before forced release. Must be >= 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- m0_valid  in  1  port 0 byte valid.
- m0_data  in  8  port 0 byte.
- m0_last  in  1  port 0: this byte ends the packet.
- m0_ready  out  1  port 0 byte accepted when valid&ready.
- m1_valid / m1_data / m1_last / m1_ready: same as port 0, for port 1.
- tx_out  out  1  serial line, idle high.
- owner_valid  out  1  a port currently holds the line.
- owner  out  1  index of the holding port; meaningful only when owner_valid=1.
- busy  out  1  serializer shifting a frame.
- timeout_err  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset values: tx_out=1; m0_ready=m1_ready=0; owner_valid=0; owner=0; busy=0; timeout_err=0. Round-robin pointer favours port 0. All counters are 0. Reset mid-frame aborts the frame immediately; tx_out returns high asynchronously with reset.
- Arbiter FSM has three states: ARB_IDLE, LOCKED, SENDING.
- ARB_IDLE:
  - If exactly one valid is high, grant that port.
  - If both are high, grant the port not granted last; port 0 wins after reset.
  - On grant: owner<=sel, owner_valid<=1, go to LOCKED on the next cycle.
  - No valid high: stay.
- LOCKED:
  - mN_ready = (state==LOCKED && owner==N). This is combinational from registered state. The non-owner's ready is always 0.
  - Handshake on valid&ready: latch data and last, start serializer, go to SENDING.
  - Idle counter increments each LOCKED cycle with owner valid low, and clears on valid high.
  - Counter reaching LOCK_TIMEOUT: pulse timeout_err, set owner_valid<=0, record owner as last-granted, go to ARB_IDLE.
- SENDING: readies are 0. When the serializer completes the stop bit:
  - latched last=1: release to ARB_IDLE with owner_valid<=0 the same cycle, and update the round-robin pointer.
  - latched last=0: return to LOCKED with the idle counter cleared.
- Serializer: 8N1, LSB first. States are TX_IDLE, TX_START, TX_DATA (bit index 0..7), TX_STOP.
  - Handshake at edge k: tx_out=0 and busy=1 from edge k+1.
  - Each bit lasts exactly BIT_PERIOD cycles, so a frame is 10*BIT_PERIOD cycles.
  - busy falls, and the arbiter leaves SENDING, on the edge ending the stop bit.
  - Back-to-back bytes: the earliest next start bit begins 2 cycles after the stop-bit end. That is 1 cycle back in LOCKED for the handshake, then the start bit.
- A requester dropping valid while not granted has no effect. Requesters must hold data and last stable while valid && !ready.
- A newly asserted valid on the non-owner never preempts a locked packet.
- A timeout release does not transmit a partial frame; only completed frames appear on the wire.

Test Plan (CLK_FREQ=1000000, BAUD_RATE=125000 → BIT_PERIOD=8, LOCK_TIMEOUT=50):
- Single-byte waveform: m0 sends 0xA5 with last=1. tx_out is low for 8 cycles, then bits 1,0,1,0,0,1,0,1 for 8 cycles each, then high for 8. Total 80 cycles. owner_valid falls when the stop bit ends.
- Packet lock: m0 sends a 3-byte packet (0x1A,0x12,0x34, last on the third) while m1_valid is held high from cycle 0. The wire carries 0x1A,0x12,0x34 before any m1 byte. m1_ready stays 0 until the m0 packet is released.
- Round robin: both ports hold 1-byte packets continuously. The wire sequence alternates 0,1,0,1, starting with port 0 after reset.
- Timeout: m0 sends 1 byte with last=0, then drops valid while m1_valid is high. timeout_err pulses exactly once, 50 cycles into the idle in LOCKED. m1 is then granted and its byte transmits.
- Reset mid-frame: assert rst_n low during bit 3 of a byte. tx_out goes high immediately, and all outputs read their reset values. After release, a fresh m1 byte 0x55 transmits correctly.
- Back-to-back spacing: m0 sends 2 bytes with valid held high. Exactly 2 cycles elapse between the stop-bit end and the next start bit.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N1 UART TX pin between two packet sources.
// Port 0 is the telemetry/sysmon stream, port 1 the SoC debug console.
// A granted port keeps the line for its whole packet (up to the byte flagged
// `last`); grants alternate round-robin between packets, and an owner that
// goes quiet mid-packet is released after LOCK_TIMEOUT idle cycles.
//
// Arbiter states:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ARB_IDLE | nobody owns the line; grant on the next valid request
//   LOCKED   | owner holds the line, ready is high, waiting for a byte
//   SENDING  | byte handed to the serializer, waiting for its stop bit
//
// Serializer states:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   TX_IDLE  | line high, waiting for a byte from the arbiter
//   TX_START | driving the start bit (low)
//   TX_DATA  | driving data bits, LSB first
//   TX_STOP  | driving the stop bit (high)

module uart_tx_arbiter #(
    parameter int CLK_FREQ     = 20000000,
    parameter int BAUD_RATE    = 125000,
    parameter int LOCK_TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       m0_valid,
    input  logic [7:0] m0_data,
    input  logic       m0_last,
    output logic       m0_ready,

    input  logic       m1_valid,
    input  logic [7:0] m1_data,
    input  logic       m1_last,
    output logic       m1_ready,

    output logic       tx_out,
    output logic       owner_valid,
    output logic       owner,
    output logic       busy,
    output logic       timeout_err
);

    localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W      = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
    localparam int IDLE_W     = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIT_PERIOD - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(LOCK_TIMEOUT - 1);

    if (BIT_PERIOD < 2) begin : g_bad_baud
        $error("uart_tx_arbiter: CLK_FREQ/BAUD_RATE must be at least 2");
    end

    if (LOCK_TIMEOUT < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: LOCK_TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        ARB_IDLE,
        LOCKED,
        SENDING
    } arb_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    arb_state_t        arb_state;
    tx_state_t         tx_state;

    // Port granted most recently; reset to 1 so port 0 wins the first tie.
    logic              last_grant;
    logic [IDLE_W-1:0] idle_cnt;
    logic [7:0]        tx_byte;
    logic              pkt_last;
    logic              tx_go;

    logic [CNT_W-1:0]  bit_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;

    logic              own_valid;
    logic [7:0]        own_data;
    logic              own_last;
    logic              grant_sel;
    logic              stop_done;

    // Readies come straight from registered state so they never depend on
    // the requesters' valid inputs.
    assign m0_ready  = (arb_state == LOCKED) && (owner == 1'b0);
    assign m1_ready  = (arb_state == LOCKED) && (owner == 1'b1);

    assign own_valid = owner ? m1_valid : m0_valid;
    assign own_data  = owner ? m1_data  : m0_data;
    assign own_last  = owner ? m1_last  : m0_last;

    // On a tie the port that was not granted last wins; otherwise the only
    // requester wins.
    assign grant_sel = (m0_valid && m1_valid) ? ~last_grant : m1_valid;

    // True on the cycle whose closing edge ends the stop bit.
    assign stop_done = (tx_state == TX_STOP) && (bit_cnt == '0);

    // Arbiter: grant, packet lock, idle timeout and round-robin update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_state   <= ARB_IDLE;
            owner       <= 1'b0;
            owner_valid <= 1'b0;
            timeout_err <= 1'b0;
            last_grant  <= 1'b1;
            idle_cnt    <= '0;
            tx_byte     <= '0;
            pkt_last    <= 1'b0;
            tx_go       <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            tx_go       <= 1'b0;
            case (arb_state)
                ARB_IDLE: begin
                    if (m0_valid || m1_valid) begin
                        owner       <= grant_sel;
                        owner_valid <= 1'b1;
                        idle_cnt    <= '0;
                        arb_state   <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (own_valid) begin
                        tx_byte   <= own_data;
                        pkt_last  <= own_last;
                        tx_go     <= 1'b1;
                        idle_cnt  <= '0;
                        arb_state <= SENDING;
                    end else if (idle_cnt == IDLE_LAST) begin
                        // This idle cycle is number LOCK_TIMEOUT: give up.
                        timeout_err <= 1'b1;
                        owner_valid <= 1'b0;
                        last_grant  <= owner;
                        idle_cnt    <= '0;
                        arb_state   <= ARB_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                SENDING: begin
                    if (stop_done) begin
                        if (pkt_last) begin
                            owner_valid <= 1'b0;
                            last_grant  <= owner;
                            arb_state   <= ARB_IDLE;
                        end else begin
                            idle_cnt  <= '0;
                            arb_state <= LOCKED;
                        end
                    end
                end
                default: begin
                    owner_valid <= 1'b0;
                    arb_state   <= ARB_IDLE;
                end
            endcase
        end
    end

    // Serializer: one 8N1 frame per tx_go pulse, each bit held BIT_PERIOD
    // cycles by a down-counter. tx_out is a flop with async set so the line
    // snaps high the moment reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_go) begin
                        shreg    <= tx_byte;
                        bit_cnt  <= BIT_LAST;
                        tx_out   <= 1'b0;
                        busy     <= 1'b1;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (bit_cnt == '0) begin
                        bit_cnt  <= BIT_LAST;
                        bit_idx  <= '0;
                        tx_out   <= shreg[0];
                        tx_state <= TX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (bit_cnt == '0) begin
                        bit_cnt <= BIT_LAST;
                        if (bit_idx == 3'd7) begin
                            tx_out   <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx_out  <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (bit_cnt == '0) begin
                        busy     <= 1'b0;
                        tx_state <= TX_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    tx_out   <= 1'b1;
                    busy     <= 1'b0;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter with BIT_PERIOD=8 and LOCK_TIMEOUT=50.
// A line monitor decodes every frame on tx_out (and who owned the line)
// into rx_q; tests compare that and sampled outputs against hand values.

module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m0_valid = 1'b0, m0_last = 1'b0, m0_ready;
    logic [7:0] m0_data = '0;
    logic       m1_valid = 1'b0, m1_last = 1'b0, m1_ready;
    logic [7:0] m1_data = '0;
    logic       tx_out, owner_valid, owner, busy, timeout_err;

    int errors = 0;
    int checks = 0;
    int to_pulses = 0;

    typedef struct {
        logic [7:0] data;
        logic       own;
        logic       stop;
    } rx_t;
    rx_t rx_q[$];

    typedef struct {
        bit         port;
        logic [7:0] data;
        logic [7:0] exp_byte;
        bit         exp_owner;
    } vec_t;
    vec_t vecs[6];

    uart_tx_arbiter #(
        .CLK_FREQ(1000000),
        .BAUD_RATE(125000),
        .LOCK_TIMEOUT(50)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .m0_valid(m0_valid),
        .m0_data(m0_data),
        .m0_last(m0_last),
        .m0_ready(m0_ready),
        .m1_valid(m1_valid),
        .m1_data(m1_data),
        .m1_last(m1_last),
        .m1_ready(m1_ready),
        .tx_out(tx_out),
        .owner_valid(owner_valid),
        .owner(owner),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (timeout_err === 1'b1) to_pulses++;

    // Line monitor: sample mid-bit (4.5 cycles into each 8-cycle bit).
    initial begin
        rx_t        r;
        logic [7:0] b;
        logic       own_at_start;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_out === 1'b0) begin
                own_at_start = owner;
                repeat (4) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (8) @(negedge clk);
                    b[i] = tx_out;
                end
                repeat (8) @(negedge clk);
                r.data = b;
                r.own  = own_at_start;
                r.stop = tx_out;
                rx_q.push_back(r);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        m0_valid = 1'b0; m1_valid = 1'b0;
        m0_last  = 1'b0; m1_last  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Present a byte and return 1 ns after the handshake edge.
    task automatic send(input bit port, input logic [7:0] d, input bit last, input bit keep);
        bit done = 1'b0;
        if (port == 1'b0) begin
            m0_valid = 1'b1; m0_data = d; m0_last = last;
        end else begin
            m1_valid = 1'b1; m1_data = d; m1_last = last;
        end
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            if ((port == 1'b0 ? m0_ready : m1_ready) === 1'b1) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        check($sformatf("handshake_p%0d_%02h", port, d), 32'(done), 1);
        if (!keep) begin
            if (port == 1'b0) m0_valid = 1'b0;
            else              m1_valid = 1'b0;
        end
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (busy === lvl) seen = 1'b1;
        end
        check(name, 32'(seen), 1);
    endtask

    task automatic wait_rx(input int n, input string name);
        for (int c = 0; c < 3000 && rx_q.size() < n; c++) @(negedge clk);
        check({name, "_rx_count"}, 32'(rx_q.size()), 32'(n));
    endtask

    task automatic check_rx(input int idx, input logic [7:0] d, input logic own, input string name);
        if (rx_q.size() > idx) begin
            check({name, "_data"},  32'(rx_q[idx].data), 32'(d));
            check({name, "_owner"}, 32'(rx_q[idx].own),  32'(own));
            check({name, "_stop"},  32'(rx_q[idx].stop), 1);
        end
    endtask

    initial begin
        logic       wave[82];
        logic       ov[82];
        logic       bz[82];
        logic [7:0] seg;
        bit         exp_lvl[10];
        int         cnt;
        int         viol;
        int         base;
        bit         m0_done;

        vecs[0] = '{port: 1'b0, data: 8'h00, exp_byte: 8'h00, exp_owner: 1'b0};
        vecs[1] = '{port: 1'b1, data: 8'hFF, exp_byte: 8'hFF, exp_owner: 1'b1};
        vecs[2] = '{port: 1'b0, data: 8'h80, exp_byte: 8'h80, exp_owner: 1'b0};
        vecs[3] = '{port: 1'b1, data: 8'h01, exp_byte: 8'h01, exp_owner: 1'b1};
        vecs[4] = '{port: 1'b0, data: 8'h3C, exp_byte: 8'h3C, exp_owner: 1'b0};
        vecs[5] = '{port: 1'b1, data: 8'hC3, exp_byte: 8'hC3, exp_owner: 1'b1};

        // start, 0xA5 LSB first (1,0,1,0,0,1,0,1), stop
        exp_lvl = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

        // Reset values while rst_n is held low
        @(negedge clk);
        check("rst_tx_out",      32'(tx_out),      1);
        check("rst_m0_ready",    32'(m0_ready),    0);
        check("rst_m1_ready",    32'(m1_ready),    0);
        check("rst_owner_valid", 32'(owner_valid), 0);
        check("rst_owner",       32'(owner),       0);
        check("rst_busy",        32'(busy),        0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        do_reset();

        // Single-byte waveform, cycle by cycle
        send(1'b0, 8'hA5, 1'b1, 1'b0);
        for (int j = 0; j < 82; j++) begin
            @(negedge clk);
            wave[j] = tx_out;
            ov[j]   = owner_valid;
            bz[j]   = busy;
        end
        check("wave_pre_start", 32'(wave[0]), 1);
        for (int p = 0; p < 10; p++) begin
            for (int s = 0; s < 8; s++) seg[s] = wave[1 + p*8 + s];
            check($sformatf("wave_period%0d", p), 32'(seg), exp_lvl[p] ? 32'hFF : 32'h00);
        end
        check("wave_busy_in_stop",  32'(bz[80]),  1);
        check("wave_owner_in_stop", 32'(ov[80]),  1);
        check("wave_owner_released", 32'(ov[81]), 0);
        check("wave_busy_fall",     32'(bz[81]),  0);
        check("wave_line_idle",     32'(wave[81]), 1);
        repeat (10) @(negedge clk);
        rx_q.delete();

        // Table of single-byte packets
        for (int v = 0; v < 6; v++) begin
            rx_q.delete();
            send(vecs[v].port, vecs[v].data, 1'b1, 1'b0);
            wait_rx(1, $sformatf("vec%0d", v));
            check_rx(0, vecs[v].exp_byte, vecs[v].exp_owner, $sformatf("vec%0d", v));
            repeat (5) @(negedge clk);
            check($sformatf("vec%0d_released", v), 32'(owner_valid), 0);
        end

        // Packet lock: m1 waits behind a 3-byte m0 packet
        do_reset();
        rx_q.delete();
        viol = 0;
        m0_done = 1'b0;
        fork
            begin
                send(1'b0, 8'h1A, 1'b0, 1'b1);
                send(1'b0, 8'h12, 1'b0, 1'b1);
                send(1'b0, 8'h34, 1'b1, 1'b0);
                wait_busy(1'b1, "lock_last_busy");
                wait_busy(1'b0, "lock_last_done");
                m0_done = 1'b1;
            end
            send(1'b1, 8'h77, 1'b1, 1'b0);
            begin
                while (!m0_done) begin
                    @(negedge clk);
                    if (!m0_done && m1_ready === 1'b1) viol++;
                end
            end
        join
        check("lock_m1_ready_during_m0", 32'(viol), 0);
        wait_rx(4, "lock");
        check_rx(0, 8'h1A, 1'b0, "lock_b0");
        check_rx(1, 8'h12, 1'b0, "lock_b1");
        check_rx(2, 8'h34, 1'b0, "lock_b2");
        check_rx(3, 8'h77, 1'b1, "lock_m1");
        repeat (10) @(negedge clk);

        // Round robin with both ports always requesting
        do_reset();
        rx_q.delete();
        base = to_pulses;
        fork
            begin
                send(1'b0, 8'h11, 1'b1, 1'b1);
                send(1'b0, 8'h22, 1'b1, 1'b0);
            end
            begin
                send(1'b1, 8'h33, 1'b1, 1'b1);
                send(1'b1, 8'h44, 1'b1, 1'b0);
            end
        join
        wait_rx(4, "rr");
        check_rx(0, 8'h11, 1'b0, "rr0");
        check_rx(1, 8'h33, 1'b1, "rr1");
        check_rx(2, 8'h22, 1'b0, "rr2");
        check_rx(3, 8'h44, 1'b1, "rr3");
        check("rr_no_timeout", 32'(to_pulses - base), 0);
        repeat (10) @(negedge clk);

        // Timeout: m0 stalls mid-packet, m1 takes over afterwards
        do_reset();
        rx_q.delete();
        base = to_pulses;
        fork
            begin
                send(1'b0, 8'h5A, 1'b0, 1'b0);
                wait_busy(1'b1, "to_busy");
                wait_busy(1'b0, "to_stop_end");
                cnt = 0;
                for (int c = 0; c < 200; c++) begin
                    @(negedge clk);
                    cnt++;
                    if (timeout_err === 1'b1) break;
                end
                check("to_latency", 32'(cnt), 50);
                check("to_owner_dropped", 32'(owner_valid), 0);
                @(negedge clk);
                check("to_pulse_width", 32'(timeout_err), 0);
            end
            send(1'b1, 8'h66, 1'b1, 1'b0);
        join
        wait_rx(2, "to");
        check_rx(0, 8'h5A, 1'b0, "to_m0");
        check_rx(1, 8'h66, 1'b1, "to_m1");
        check("to_pulse_count", 32'(to_pulses - base), 1);
        repeat (10) @(negedge clk);

        // Back-to-back spacing within one packet
        rx_q.delete();
        fork
            begin
                send(1'b0, 8'hB1, 1'b0, 1'b1);
                send(1'b0, 8'hB2, 1'b1, 1'b0);
            end
            begin
                wait_busy(1'b1, "b2b_busy");
                wait_busy(1'b0, "b2b_stop_end");
                cnt = 0;
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    cnt++;
                    if (tx_out === 1'b0) break;
                end
                check("b2b_gap", 32'(cnt), 2);
            end
        join
        wait_rx(2, "b2b");
        check_rx(0, 8'hB1, 1'b0, "b2b0");
        check_rx(1, 8'hB2, 1'b0, "b2b1");
        repeat (10) @(negedge clk);

        // Reset during data bit 3 of 0xF0 (bit 3 = 0)
        send(1'b1, 8'hF0, 1'b1, 1'b0);
        wait_busy(1'b1, "mid_busy");
        repeat (35) @(negedge clk);
        check("mid_bit3_low", 32'(tx_out), 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_tx_out",      32'(tx_out),      1);
        check("mid_m0_ready",    32'(m0_ready),    0);
        check("mid_m1_ready",    32'(m1_ready),    0);
        check("mid_owner_valid", 32'(owner_valid), 0);
        check("mid_owner",       32'(owner),       0);
        check("mid_busy",        32'(busy),        0);
        check("mid_timeout_err", 32'(timeout_err), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        rx_q.delete();
        send(1'b1, 8'h55, 1'b1, 1'b0);
        wait_rx(1, "post_rst");
        check_rx(0, 8'h55, 1'b1, "post_rst");
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
